// File: rtl/mem_access_unit.sv
// MEM stage of the 5-stage MIPS pipeline: runs LW/LH/LB/SW/SH/SB on a req/ack data
// bus, stalls while an access is outstanding, and registers the MEM/WB result.

`ifndef ALU_OP_BUS_DEFS
`define ALU_OP_BUS_DEFS
`define AluOpBus   7:0
`define ALU_OP_NOP 8'b00000000
`define ALU_OP_ORI 8'b00100101
`define ALU_OP_ADD 8'b00100000
`define ALU_OP_LB  8'b11100000
`define ALU_OP_LH  8'b11100001
`define ALU_OP_LW  8'b11100011
`define ALU_OP_SB  8'b11101000
`define ALU_OP_SH  8'b11101001
`define ALU_OP_SW  8'b11101011
`endif

module mem_access_unit #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [`AluOpBus] aluop_i,
  input  logic [4:0]       wd_i,
  input  logic             wreg_i,
  input  logic [31:0]      wdata_i,
  input  logic [31:0]      mem_addr_i,
  input  logic [31:0]      reg2_i,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      dbus_rdata_i,
  input  logic             dbus_ack_i,
  output logic             dbus_req_o,
  output logic             dbus_we_o,
  output logic [31:0]      dbus_addr_o,
  output logic [3:0]       dbus_be_o,
  output logic [31:0]      dbus_wdata_o,
  output logic             stallreq_o,
  output logic [4:0]       wd_o,
  output logic             wreg_o,
  output logic [31:0]      wdata_o,
  output logic [31:0]      pc_o,
  output logic [1:0]       exc_o,
  output logic [31:0]      badvaddr_o
);

  // Handshake: dbus_req_o rises on the edge leaving IDLE and stays high, with
  // addr/we/be/wdata stable, until the edge on which dbus_ack_i=1 is sampled
  // (or the timeout fires); an ack seen in IDLE is ignored.

  typedef enum logic { S_IDLE = 1'b0, S_REQ = 1'b1 } state_t;

  localparam logic [1:0] SZ_NONE = 2'd0;
  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;
  localparam logic [1:0] SZ_WORD = 2'd3;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_ADEL = 2'b01;
  localparam logic [1:0] EXC_ADES = 2'b10;
  localparam logic [1:0] EXC_BUS  = 2'b11;

  localparam logic [CNT_W:0] TO_LIM = (CNT_W + 1)'(TIMEOUT);

  function automatic logic [1:0] op_size(input logic [`AluOpBus] op);
    case (op)
      `ALU_OP_LB, `ALU_OP_SB: op_size = SZ_BYTE;
      `ALU_OP_LH, `ALU_OP_SH: op_size = SZ_HALF;
      `ALU_OP_LW, `ALU_OP_SW: op_size = SZ_WORD;
      default:                op_size = SZ_NONE;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [`AluOpBus] op);
    op_is_store = (op == `ALU_OP_SB) || (op == `ALU_OP_SH) || (op == `ALU_OP_SW);
  endfunction

  function automatic logic [31:0] fmt_load(input logic [`AluOpBus] op,
                                            input logic [1:0] a,
                                            input logic [31:0] d);
    logic [15:0] h;
    logic [7:0]  b;
    h = a[1] ? d[31:16] : d[15:0];
    case (a)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    case (op_size(op))
      SZ_BYTE: fmt_load = {{24{b[7]}}, b};
      SZ_HALF: fmt_load = {{16{h[15]}}, h};
      default: fmt_load = d;
    endcase
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [`AluOpBus]   op_q, op_d;
  logic [31:0]        vaddr_q, vaddr_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [3:0]         be_q, be_d;
  logic [31:0]        bwdata_q, bwdata_d;
  logic [4:0]         wd_q, wd_d;
  logic               wreg_q, wreg_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        pc_q, pc_d;
  logic [1:0]         exc_q, exc_d;
  logic [31:0]        badvaddr_q, badvaddr_d;
  logic               stall;

  logic [1:0]         in_size;
  logic               in_is_mem;
  logic               in_is_store;
  logic               in_misaligned;
  logic [3:0]         in_be;
  logic [31:0]        in_bwdata;
  logic [CNT_W:0]     cnt_inc;
  logic               timeout_hit;

  always_comb begin
    in_size       = op_size(aluop_i);
    in_is_mem     = (in_size != SZ_NONE);
    in_is_store   = op_is_store(aluop_i);
    in_misaligned = ((in_size == SZ_HALF) && mem_addr_i[0]) ||
                    ((in_size == SZ_WORD) && (mem_addr_i[1:0] != 2'b00));
    case (in_size)
      SZ_BYTE: in_be = 4'b0001 << mem_addr_i[1:0];
      SZ_HALF: in_be = mem_addr_i[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: in_be = 4'b1111;
      default: in_be = 4'b0000;
    endcase
    case (in_size)
      SZ_BYTE: in_bwdata = {4{reg2_i[7:0]}};
      SZ_HALF: in_bwdata = {2{reg2_i[15:0]}};
      default: in_bwdata = reg2_i;
    endcase
    cnt_inc     = {1'b0, cnt_q} + 1'b1;
    timeout_hit = (TIMEOUT != 0) && (state_q == S_REQ) && (cnt_inc == TO_LIM);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    vaddr_d    = vaddr_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    bwdata_d   = bwdata_q;
    // Writeback defaults to a bubble; each path overrides what it produces.
    wd_d       = 5'd0;
    wreg_d     = 1'b0;
    wdata_d    = 32'd0;
    pc_d       = pc_i;
    exc_d      = EXC_NONE;
    badvaddr_d = 32'd0;
    stall      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!in_is_mem) begin
          wd_d    = wd_i;
          wreg_d  = wreg_i;
          wdata_d = wdata_i;
        end else if (in_misaligned) begin
          exc_d      = in_is_store ? EXC_ADES : EXC_ADEL;
          badvaddr_d = mem_addr_i;
        end else begin
          stall    = 1'b1;
          state_d  = S_REQ;
          cnt_d    = '0;
          op_d     = aluop_i;
          vaddr_d  = mem_addr_i;
          req_d    = 1'b1;
          we_d     = in_is_store;
          addr_d   = {mem_addr_i[31:2], 2'b00};
          be_d     = in_be;
          bwdata_d = in_bwdata;
        end
      end
      S_REQ: begin
        stall = ~dbus_ack_i & ~timeout_hit;
        if (dbus_ack_i) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
          cnt_d   = '0;
          if (!op_is_store(op_q)) begin
            wd_d    = wd_i;
            wreg_d  = wreg_i;
            wdata_d = fmt_load(op_q, vaddr_q[1:0], dbus_rdata_i);
          end
        end else if (timeout_hit) begin
          req_d      = 1'b0;
          state_d    = S_IDLE;
          cnt_d      = '0;
          exc_d      = EXC_BUS;
          badvaddr_d = vaddr_q;
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      vaddr_q    <= 32'd0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      be_q       <= 4'd0;
      bwdata_q   <= 32'd0;
      wd_q       <= 5'd0;
      wreg_q     <= 1'b0;
      wdata_q    <= 32'd0;
      pc_q       <= 32'd0;
      exc_q      <= EXC_NONE;
      badvaddr_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      vaddr_q    <= vaddr_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      bwdata_q   <= bwdata_d;
      wd_q       <= wd_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
      pc_q       <= pc_d;
      exc_q      <= exc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  assign dbus_req_o   = req_q;
  assign dbus_we_o    = we_q;
  assign dbus_addr_o  = addr_q;
  assign dbus_be_o    = be_q;
  assign dbus_wdata_o = bwdata_q;
  assign stallreq_o   = stall;
  assign wd_o         = wd_q;
  assign wreg_o       = wreg_q;
  assign wdata_o      = wdata_q;
  assign pc_o         = pc_q;
  assign exc_o        = exc_q;
  assign badvaddr_o   = badvaddr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus randomized transactions checked
// against an arithmetic model of the MEM-stage rules.

`ifndef ALU_OP_BUS_DEFS
`define ALU_OP_BUS_DEFS
`define AluOpBus   7:0
`define ALU_OP_NOP 8'b00000000
`define ALU_OP_ORI 8'b00100101
`define ALU_OP_ADD 8'b00100000
`define ALU_OP_LB  8'b11100000
`define ALU_OP_LH  8'b11100001
`define ALU_OP_LW  8'b11100011
`define ALU_OP_SB  8'b11101000
`define ALU_OP_SH  8'b11101001
`define ALU_OP_SW  8'b11101011
`endif

module tb_mem_access_unit;

  localparam int TO = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [`AluOpBus] aluop_i = '0;
  logic [4:0]       wd_i = '0;
  logic             wreg_i = 1'b0;
  logic [31:0]      wdata_i = '0;
  logic [31:0]      mem_addr_i = '0;
  logic [31:0]      reg2_i = '0;
  logic [31:0]      pc_i = '0;
  logic [31:0]      dbus_rdata_i = '0;
  logic             dbus_ack_i = 1'b0;
  logic             dbus_req_o, dbus_we_o, stallreq_o, wreg_o;
  logic [31:0]      dbus_addr_o, dbus_wdata_o, wdata_o, pc_o, badvaddr_o;
  logic [3:0]       dbus_be_o;
  logic [4:0]       wd_o;
  logic [1:0]       exc_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  mem_access_unit #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .wdata_i(wdata_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .pc_i(pc_i),
    .dbus_rdata_i(dbus_rdata_i), .dbus_ack_i(dbus_ack_i), .dbus_req_o(dbus_req_o),
    .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o), .dbus_be_o(dbus_be_o),
    .dbus_wdata_o(dbus_wdata_o), .stallreq_o(stallreq_o), .wd_o(wd_o),
    .wreg_o(wreg_o), .wdata_o(wdata_o), .pc_o(pc_o), .exc_o(exc_o),
    .badvaddr_o(badvaddr_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference model
  function automatic int op_bytes(input logic [`AluOpBus] op);
    case (op)
      `ALU_OP_LB, `ALU_OP_SB: return 1;
      `ALU_OP_LH, `ALU_OP_SH: return 2;
      `ALU_OP_LW, `ALU_OP_SW: return 4;
      default:                return 0;
    endcase
  endfunction

  function automatic bit op_store(input logic [`AluOpBus] op);
    return (op == `ALU_OP_SB) || (op == `ALU_OP_SH) || (op == `ALU_OP_SW);
  endfunction

  function automatic logic [3:0] model_be(input int nb, input logic [31:0] addr);
    int lane;
    lane = int'(addr % 4);
    return 4'(((1 << nb) - 1) << lane);
  endfunction

  function automatic logic [31:0] model_bus_wdata(input int nb, input logic [31:0] reg2);
    if (nb == 1) return 32'(reg2 % 256) * 32'h01010101;
    if (nb == 2) return 32'(reg2 % 65536) * 32'h00010001;
    return reg2;
  endfunction

  function automatic logic [31:0] model_load(input int nb, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    longint v;
    longint span;
    span = longint'(1) << (8 * nb);
    v = (longint'(rdata) >> (8 * int'(addr % 4))) % span;
    if (nb < 4 && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  // Driver: one EX-stage instruction; waits = REQ cycles without ack before
  // the ack cycle (waits >= TO means the bus never answers).
  task automatic do_txn(input logic [`AluOpBus] op, input logic [31:0] addr,
                        input logic [31:0] reg2, input logic [4:0] wd, input logic wreg,
                        input logic [31:0] wdata, input logic [31:0] pc,
                        input int waits, input logic [31:0] rdata);
    int  nb, stall_cnt, req_cycles, guard, exp_cycles;
    bit  is_mem, aligned, st, timed_out;
    logic [31:0] got_w;
    nb = op_bytes(op);
    is_mem = (nb != 0);
    st = op_store(op);
    aligned = is_mem && (addr % nb == 0);
    timed_out = aligned && (waits >= TO);
    exp_cycles = timed_out ? TO : waits + 1;
    aluop_i = op; mem_addr_i = addr; reg2_i = reg2; wd_i = wd; wreg_i = wreg;
    wdata_i = wdata; pc_i = pc; dbus_ack_i = 1'b0;
    stall_cnt = 0; req_cycles = 0;
    #1;
    if (stallreq_o) stall_cnt++;
    @(posedge clk); @(negedge clk);
    if (aligned) begin
      check("req_up", 32'(dbus_req_o), 32'd1);
      check("bus_we", 32'(dbus_we_o), 32'(st));
      check("bus_be", 32'(dbus_be_o), 32'(model_be(nb, addr)));
      check("bus_wdata", dbus_wdata_o & {{8{dbus_be_o[3]}}, {8{dbus_be_o[2]}},
            {8{dbus_be_o[1]}}, {8{dbus_be_o[0]}}},
            st ? model_bus_wdata(nb, reg2) & {{8{model_be(nb, addr) >> 3 == 1}},
            {8{(model_be(nb, addr) >> 2) % 2 == 1}}, {8{(model_be(nb, addr) >> 1) % 2 == 1}},
            {8{model_be(nb, addr) % 2 == 1}}} : dbus_wdata_o & {{8{dbus_be_o[3]}},
            {8{dbus_be_o[2]}}, {8{dbus_be_o[1]}}, {8{dbus_be_o[0]}}});
      guard = 0;
      while (dbus_req_o && guard < 50) begin
        req_cycles++;
        check("bus_addr", dbus_addr_o, addr - (addr % 4));
        if (!timed_out && req_cycles == waits + 1) begin
          dbus_ack_i = 1'b1;
          dbus_rdata_i = rdata;
        end
        #1;
        if (stallreq_o) stall_cnt++;
        @(posedge clk); @(negedge clk);
        dbus_ack_i = 1'b0;
        dbus_rdata_i = $urandom;
        guard++;
      end
      check("req_cycles", 32'(req_cycles), 32'(exp_cycles));
      check("stall_cycles", 32'(stall_cnt), 32'(exp_cycles));
    end else begin
      check("no_req", 32'(dbus_req_o), 32'd0);
      check("no_stall", 32'(stall_cnt), 32'd0);
    end
    // Expected writeback goes through the scoreboard queue.
    if (!is_mem) begin
      exp_q.push_back(wdata);
    end else if (aligned && !timed_out && !st) begin
      exp_q.push_back(model_load(nb, addr, rdata));
    end
    if (!is_mem || (aligned && !timed_out && !st)) begin
      check("wreg", 32'(wreg_o), 32'(wreg));
      check("wd", 32'(wd_o), 32'(wd));
      check("pc", pc_o, pc);
      got_w = wdata_o;
      check("wdata", got_w, exp_q.pop_front());
      check("exc", 32'(exc_o), 32'd0);
      check("badvaddr", badvaddr_o, 32'd0);
    end else if (!aligned) begin
      check("wreg_exc", 32'(wreg_o), 32'd0);
      check("exc_adr", 32'(exc_o), st ? 32'd2 : 32'd1);
      check("badvaddr_adr", badvaddr_o, addr);
      check("pc_adr", pc_o, pc);
    end else if (timed_out) begin
      check("wreg_to", 32'(wreg_o), 32'd0);
      check("exc_to", 32'(exc_o), 32'd3);
      check("badvaddr_to", badvaddr_o, addr);
    end else begin
      check("wreg_st", 32'(wreg_o), 32'd0);
      check("exc_st", 32'(exc_o), 32'd0);
      check("badvaddr_st", badvaddr_o, 32'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, 32'(dbus_req_o), 32'd0);
    check({tag, "_we"}, 32'(dbus_we_o), 32'd0);
    check({tag, "_addr"}, dbus_addr_o, 32'd0);
    check({tag, "_be"}, 32'(dbus_be_o), 32'd0);
    check({tag, "_bwdata"}, dbus_wdata_o, 32'd0);
    check({tag, "_wd"}, 32'(wd_o), 32'd0);
    check({tag, "_wreg"}, 32'(wreg_o), 32'd0);
    check({tag, "_wdata"}, wdata_o, 32'd0);
    check({tag, "_pc"}, pc_o, 32'd0);
    check({tag, "_exc"}, 32'(exc_o), 32'd0);
    check({tag, "_bad"}, badvaddr_o, 32'd0);
  endtask

  initial begin
    logic [`AluOpBus] ops[8];
    logic [31:0] a;
    ops[0] = `ALU_OP_ORI; ops[1] = `ALU_OP_ADD; ops[2] = `ALU_OP_LW; ops[3] = `ALU_OP_LH;
    ops[4] = `ALU_OP_LB;  ops[5] = `ALU_OP_SW;  ops[6] = `ALU_OP_SH; ops[7] = `ALU_OP_SB;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset");

    do_txn(`ALU_OP_ORI, 32'h0, 32'h0, 5'd3, 1'b1, 32'h0000FFFF, 32'h100, 0, 32'h0);
    do_txn(`ALU_OP_LB, 32'h1003, 32'h0, 5'd5, 1'b1, 32'h0, 32'h104, 2, 32'h80FF7F01);
    do_txn(`ALU_OP_SH, 32'h2002, 32'h1234ABCD, 5'd0, 1'b0, 32'h0, 32'h108, 0, 32'h0);
    do_txn(`ALU_OP_LW, 32'h3001, 32'h0, 5'd6, 1'b1, 32'h0, 32'h10C, 0, 32'h0);
    do_txn(`ALU_OP_SW, 32'h3002, 32'h55, 5'd0, 1'b0, 32'h0, 32'h110, 0, 32'h0);
    do_txn(`ALU_OP_LW, 32'h4000, 32'h0, 5'd7, 1'b1, 32'h0, 32'h114, 100, 32'h0);
    do_txn(`ALU_OP_LH, 32'h5002, 32'h0, 5'd8, 1'b1, 32'h0, 32'h118, TO - 1, 32'h8001_7FFF);
    do_txn(`ALU_OP_LH, 32'h5003, 32'h0, 5'd8, 1'b1, 32'h0, 32'h11C, 0, 32'h0);

    // Reset in the second REQ cycle, then a stray ack.
    aluop_i = `ALU_OP_LW; mem_addr_i = 32'h6000; wd_i = 5'd9; wreg_i = 1'b1; pc_i = 32'h120;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    check("mid_req", 32'(dbus_req_o), 32'd1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    aluop_i = `ALU_OP_NOP; mem_addr_i = 32'h0; wd_i = 5'd0; wreg_i = 1'b0; pc_i = 32'h0;
    wdata_i = 32'h0; dbus_ack_i = 1'b1; dbus_rdata_i = 32'hDEADBEEF;
    #1;
    check_all_zero("rst_mid");
    check("rst_mid_stall", 32'(stallreq_o), 32'd0);
    @(posedge clk); @(negedge clk);
    dbus_ack_i = 1'b0;
    check_all_zero("stray_ack");

    for (int i = 0; i < 60; i++) begin
      logic [`AluOpBus] op;
      op = ops[$urandom_range(0, 7)];
      a = {$urandom_range(0, 255), 2'b00} + 32'(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      do_txn(op, a, $urandom, 5'($urandom_range(1, 31)), 1'b1, $urandom,
             32'h1000 + 32'(i * 4), $urandom_range(0, TO + 1), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM stage of the 5-stage MIPS pipeline. It consumes the EX stage results (aluop, mem_addr, reg2, wd/wreg/wdata, pc) and runs loads and stores (LW/LH/LB/SW/SH/SB) on the data bus with a req/ack handshake.
- It stalls the pipeline while a bus access is outstanding.
- It registers the writeback result and any exception into the MEM/WB boundary.

Parameters:
- TIMEOUT, 255, max cycles in REQ without ack before abort with bus error; 0 disables the timeout.
- CNT_W, 8, timeout counter width; must satisfy TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- aluop_i  in  `AluOpBus  EX op code; decodes `ALU_OP_LW/LH/LB/SW/SH/SB, all others are non-memory.
- wd_i  in  5  destination register.
- wreg_i  in  1  register write enable.
- wdata_i  in  32  EX result for non-memory ops.
- mem_addr_i  in  32  effective address.
- reg2_i  in  32  store data.
- pc_i  in  32  instruction pc.
- dbus_rdata_i  in  32  read data, valid when dbus_ack_i=1.
- dbus_ack_i  in  1  bus acknowledge.
- dbus_req_o  out  1  bus request.
- dbus_we_o  out  1  1=store.
- dbus_addr_o  out  32  word address {addr[31:2],2'b00}.
- dbus_be_o  out  4  byte enables, bit n = byte lane n.
- dbus_wdata_o  out  32  lane-replicated store data.
- stallreq_o  out  1  pipeline stall request, combinational.
- wd_o  out  5  registered destination.
- wreg_o  out  1  registered write enable.
- wdata_o  out  32  registered writeback data.
- pc_o  out  32  registered pc.
- exc_o  out  2  registered exception: 00 none, 01 ADEL, 10 ADES, 11 BUSERR.
- badvaddr_o  out  32  registered faulting address; 0 when exc_o=00.

Behaviour:
- Reset (rst=1 at an edge):
  - State is IDLE and the counter is 0.
  - dbus_req_o=0, dbus_we_o=0, dbus_addr_o=0, dbus_be_o=0, dbus_wdata_o=0.
  - wd_o=0, wreg_o=0, wdata_o=0, pc_o=0, exc_o=00, badvaddr_o=0.
  - Reset mid-access abandons the request. Any later ack is ignored while in IDLE.
- FSM states: IDLE, REQ.
- IDLE with a non-memory op:
  - stallreq_o=0.
  - Next edge loads wd/wreg/wdata/pc into the outputs, exc_o=00.
  - Latency is 1 cycle.
- IDLE with an aligned memory op:
  - stallreq_o=1 combinationally.
  - Next edge latches bus address, we, be and wdata into the dbus_* registers and sets req=1; state becomes REQ.
  - Outputs load a bubble (wreg_o=0, wd_o=0, wdata_o=0, exc_o=00).
- IDLE with a misaligned memory op (LH/SH addr[0]=1; LW/SW addr[1:0]!=0):
  - No bus request and no stall.
  - Next edge: wreg_o=0, exc_o=01 for loads or 10 for stores, badvaddr_o=mem_addr_i, pc_o=pc_i.
- REQ state:
  - dbus_* are held stable and the counter increments each cycle.
  - stallreq_o = ~dbus_ack_i. Upstream holds its inputs while stallreq_o=1.
  - On ack at an edge: req=0, state IDLE, counter 0.
    - Store: outputs wreg_o=0.
    - Load: outputs wd_i, wreg_i, formatted rdata, pc_i.
  - Minimum memory-op latency is 2 cycles (ack in the first REQ cycle). Each wait state adds 1.
- Timeout: when TIMEOUT!=0 and the counter reaches TIMEOUT with no ack, on that edge:
  - req=0, state IDLE.
  - exc_o=11, badvaddr_o=latched address, wreg_o=0.
  - stallreq_o is 0 in that cycle.
- Byte enables and store data:
  - SW: be=1111, wdata=reg2.
  - SH: be=0011 (addr[1]=0) or 1100 (addr[1]=1), wdata={2{reg2[15:0]}}.
  - SB: be=0001<<addr[1:0], wdata={4{reg2[7:0]}}.
  - Loads use the same be pattern as the store of the same size, with we=0.
- Load formatting, little-endian:
  - LW: rdata.
  - LH: sign-extend rdata[16*addr[1] +: 16].
  - LB: sign-extend rdata[8*addr[1:0] +: 8].
- A simultaneous ack and timeout edge counts as ack (success).
- dbus_req_o is never asserted in IDLE. An ack arriving while in IDLE is ignored.

Test Plan:
- ORI result: aluop=ORI, wd=3, wreg=1, wdata=0x0000FFFF -> next cycle wd_o=3, wreg_o=1, wdata_o=0x0000FFFF, stallreq_o never high.
- LB with 2 wait states: addr=0x1003, rdata=0x80FF7F01, ack in 3rd REQ cycle -> dbus_addr_o=0x1000, be=1000, stallreq_o high 3 cycles, wdata_o=0xFFFFFF80.
- SH at addr 0x2002, reg2=0x1234ABCD, zero-wait ack -> we=1, be=1100, dbus_wdata_o=0xABCDABCD, wreg_o=0, stall for 1 cycle only.
- Misaligned LW at 0x3001 -> no dbus_req_o, exc_o=01, badvaddr_o=0x3001, wreg_o=0. SW at 0x3002 -> exc_o=10.
- Timeout with TIMEOUT=4 and no ack -> req drops after 4 REQ cycles, exc_o=11, badvaddr_o=the address, pipeline resumes.
- rst asserted in 2nd REQ cycle, then a stray ack -> all outputs 0, state IDLE, no writeback.
